binary_decoder: RTL and testbench

BINARY_DECODER -- requirements
Module: binary_decoder

---
 rtl/binary_decoder_pkg.sv | 9 +
 rtl/decoder_fifo2.sv | 55 +++++
 rtl/binary_decoder.sv | 52 +++++
 tb/tb_binary_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/binary_decoder_pkg.sv
// binary_decoder_pkg: shared occupancy encoding and buffer depth for the binary decoder
package binary_decoder_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;
    localparam int FIFO_DEPTH = 2;
endpackage

// File: rtl/decoder_fifo2.sv
// decoder_fifo2: two-entry pointer/count FIFO; the read port shows zero while empty
module decoder_fifo2
    import binary_decoder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         can_push,
    output logic         can_pop
);
    occ_e count_q, count_d;
    logic wr_ptr_q, wr_ptr_d;
    logic rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [FIFO_DEPTH];
    logic [W-1:0] mem_d [FIFO_DEPTH];
    logic do_push, do_pop;

    assign can_push = count_q != FULL;
    assign can_pop  = count_q != EMPTY;
    assign do_push  = push && can_push;
    assign do_pop   = pop && can_pop;
    assign rdata    = can_pop ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = wdata;
        wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
        count_d  = (do_push && !do_pop) ? (count_q == EMPTY ? ONE : FULL)
                 : (do_pop && !do_push) ? (count_q == FULL ? ONE : EMPTY)
                 : count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // storage is never observed while empty, so it carries no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/binary_decoder.sv
// binary_decoder: decodes a binary index to a one-hot word at input transfer and buffers it
// in a two-entry FIFO; flags out-of-range indices with a sticky error bit.
module binary_decoder
    import binary_decoder_pkg::*;
#(
    parameter  int NUM_OUTPUTS = 4,
    localparam int IDX_W       = $clog2(NUM_OUTPUTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IDX_W-1:0]       in_index,
    input  logic                   in_enable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_OUTPUTS-1:0] out_onehot,
    output logic                   out_error,
    input  logic                   clear_error
);
    localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(NUM_OUTPUTS);

    logic                   in_xfer;
    logic                   in_range;
    logic [NUM_OUTPUTS-1:0] word;
    logic                   err_q, err_d;

    assign in_xfer   = in_valid && in_ready;
    assign in_range  = {1'b0, in_index} < LIMIT;
    assign out_error = err_q;

    always_comb begin
        word  = (in_enable && in_range) ? ({{(NUM_OUTPUTS-1){1'b0}}, 1'b1} << in_index) : '0;
        err_d = (in_xfer && in_enable && !in_range) ? 1'b1 : clear_error ? 1'b0 : err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    decoder_fifo2 #(.W(NUM_OUTPUTS)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .pop      (out_ready),
        .wdata    (word),
        .rdata    (out_onehot),
        .can_push (in_ready),
        .can_pop  (out_valid)
    );
endmodule

// File: tb/tb_binary_decoder.sv
// tb_binary_decoder: table-driven, directed and randomized checks of binary_decoder
// for NUM_OUTPUTS=4 (dut a) and NUM_OUTPUTS=5 (dut b).
module tb_binary_decoder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic a_in_valid = 0, a_in_ready, a_in_enable = 0, a_out_valid, a_out_ready = 0;
    logic a_out_error, a_clear_error = 0;
    logic [1:0] a_in_index = 0;
    logic [3:0] a_out_onehot;

    logic b_in_valid = 0, b_in_ready, b_in_enable = 0, b_out_valid, b_out_ready = 0;
    logic b_out_error, b_clear_error = 0;
    logic [2:0] b_in_index = 0;
    logic [4:0] b_out_onehot;

    binary_decoder #(.NUM_OUTPUTS(4)) dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_index(a_in_index), .in_enable(a_in_enable), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_onehot(a_out_onehot), .out_error(a_out_error),
        .clear_error(a_clear_error)
    );

    binary_decoder #(.NUM_OUTPUTS(5)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_index(b_in_index), .in_enable(b_in_enable), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_onehot(b_out_onehot), .out_error(b_out_error),
        .clear_error(b_clear_error)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_dec(input int n, input int idx, input bit en);
        return (en && idx < n) ? (64'd1 << idx) : 64'd0;
    endfunction

    typedef struct {
        logic [1:0] idx;
        logic       en;
        logic [3:0] exp;
    } vec_t;

    initial begin
        vec_t tbl[5];
        logic [4:0] q[$];
        logic [4:0] prev_word;
        bit prev_stall, m_err, push, pop;
        int delivered;
        tbl[0] = '{2'd0, 1'b1, 4'b0001};
        tbl[1] = '{2'd1, 1'b1, 4'b0010};
        tbl[2] = '{2'd2, 1'b1, 4'b0100};
        tbl[3] = '{2'd3, 1'b1, 4'b1000};
        tbl[4] = '{2'd2, 1'b0, 4'b0000};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_a_valid", a_out_valid, 0);
        chk("rst_a_ready", a_in_ready, 1);
        chk("rst_a_onehot", a_out_onehot, 0);
        chk("rst_a_error", a_out_error, 0);
        chk("rst_b_valid", b_out_valid, 0);
        chk("rst_b_ready", b_in_ready, 1);
        rst = 1'b0;

        // back-to-back decode with the sink always ready
        a_out_ready = 1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            a_in_valid = 1; a_in_index = tbl[i].idx; a_in_enable = tbl[i].en;
            @(negedge clk);
            chk("tbl_valid", a_out_valid, 1);
            chk("tbl_onehot", a_out_onehot, tbl[i].exp);
            chk("tbl_ready", a_in_ready, 1);
            chk("tbl_error", a_out_error, 0);
        end
        a_in_valid = 0;
        @(negedge clk);
        chk("tbl_drain_valid", a_out_valid, 0);
        chk("tbl_drain_onehot", a_out_onehot, 0);

        // backpressure: fill, refuse third, accept it the cycle after the first pop
        a_out_ready = 0;
        a_in_valid = 1; a_in_enable = 1; a_in_index = 2;
        @(negedge clk);
        chk("bp_one_valid", a_out_valid, 1);
        chk("bp_one_onehot", a_out_onehot, 4'b0100);
        chk("bp_one_ready", a_in_ready, 1);
        a_in_index = 1;
        @(negedge clk);
        chk("bp_full_ready", a_in_ready, 0);
        chk("bp_full_onehot", a_out_onehot, 4'b0100);
        a_in_index = 3; a_out_ready = 1;
        @(negedge clk);
        chk("bp_pop1_onehot", a_out_onehot, 4'b0010);
        chk("bp_pop1_ready", a_in_ready, 1);
        @(negedge clk);
        chk("bp_pop2_onehot", a_out_onehot, 4'b1000);
        chk("bp_pop2_valid", a_out_valid, 1);
        a_in_valid = 0;
        @(negedge clk);
        chk("bp_empty_valid", a_out_valid, 0);

        // asynchronous reset while full
        a_out_ready = 0; a_in_valid = 1; a_in_index = 0;
        @(negedge clk);
        a_in_index = 3;
        @(negedge clk);
        chk("ar_full_ready", a_in_ready, 0);
        a_in_valid = 0;
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", a_out_valid, 0);
        chk("ar_ready", a_in_ready, 1);
        chk("ar_onehot", a_out_onehot, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        a_in_valid = 1; a_in_index = 1;
        @(negedge clk);
        chk("ar_after_valid", a_out_valid, 1);
        chk("ar_after_onehot", a_out_onehot, 4'b0010);
        a_in_valid = 0; a_out_ready = 1;
        @(negedge clk);

        // out-of-range error, sticky, clear, and set-wins
        b_out_ready = 1;
        b_in_valid = 1; b_in_enable = 1; b_in_index = 6;
        @(negedge clk);
        chk("oor_valid", b_out_valid, 1);
        chk("oor_onehot", b_out_onehot, 0);
        chk("oor_error", b_out_error, 1);
        b_in_enable = 0; b_in_index = 2;
        @(negedge clk);
        chk("dis_valid", b_out_valid, 1);
        chk("dis_onehot", b_out_onehot, 0);
        chk("dis_error_kept", b_out_error, 1);
        b_in_valid = 0; b_clear_error = 1;
        @(negedge clk);
        chk("clr_error", b_out_error, 0);
        b_in_valid = 1; b_in_enable = 1; b_in_index = 6;
        @(negedge clk);
        chk("setwins_error", b_out_error, 1);
        b_in_valid = 0; b_clear_error = 0;
        @(negedge clk);
        chk("sticky_error", b_out_error, 1);

        // randomized traffic against a queue model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_err = 0; delivered = 0; prev_stall = 0; prev_word = 0;
        for (int cyc = 0; cyc < 6000 && delivered < 1000; cyc++) begin
            chk("rnd_valid", b_out_valid, q.size() > 0);
            chk("rnd_ready", b_in_ready, q.size() < 2);
            chk("rnd_onehot", b_out_onehot, q.size() > 0 ? q[0] : 5'd0);
            chk("rnd_error", b_out_error, m_err);
            if (prev_stall) chk("rnd_stable", b_out_onehot, prev_word);
            b_in_valid    = $urandom_range(0, 3) != 0;
            b_in_index    = 3'($urandom_range(0, 7));
            b_in_enable   = $urandom_range(0, 7) != 0;
            b_out_ready   = $urandom_range(0, 2) != 0;
            b_clear_error = $urandom_range(0, 15) == 0;
            prev_stall = q.size() > 0 && !b_out_ready;
            prev_word  = b_out_onehot;
            push = b_in_valid && q.size() < 2;
            pop  = b_out_ready && q.size() > 0;
            m_err = (push && b_in_enable && b_in_index >= 5) ? 1'b1 : b_clear_error ? 1'b0 : m_err;
            if (pop) begin
                void'(q.pop_front());
                delivered++;
            end
            if (push) q.push_back(5'(ref_dec(5, int'(b_in_index), b_in_enable)));
            @(negedge clk);
        end
        chk("rnd_delivered", delivered >= 1000, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
